// File: rtl/riscv_fetch_align.sv
// Fetch realignment: extracts the RVC/32-bit instruction at pc from the fetched word and drives next-PC.
// Optional compressed support is built when RISCV_FALIGN_RVC_EN is defined.
module riscv_fetch_align #(
    parameter int width = 64
) (
    input  logic             i_riscv_falign_clk,
    input  logic             i_riscv_falign_rst_n,
    input  logic [width-1:0] i_riscv_falign_pc,
    input  logic             i_riscv_falign_rvalid,
    input  logic [31:0]      i_riscv_falign_rdata,
    input  logic             i_riscv_falign_stall,
    input  logic             i_riscv_falign_flush,
    input  logic [width-1:0] i_riscv_falign_target,
    output logic [width-1:0] o_riscv_falign_nextpc,
    output logic             o_riscv_falign_stallpc,
    output logic [31:0]      o_riscv_falign_instr,
    output logic [width-1:0] o_riscv_falign_instr_pc,
    output logic             o_riscv_falign_instr_valid,
    output logic             o_riscv_falign_is_compressed,
    output logic             o_riscv_falign_misalign
);

    logic             adv;
    logic             emit;
    logic [31:0]      emit_instr;
    logic [width-1:0] emit_pc;
    logic             emit_c;
    logic [width-1:0] step_pc;

    assign adv = i_riscv_falign_rvalid && !i_riscv_falign_stall && !i_riscv_falign_flush;
    assign o_riscv_falign_stallpc = !adv && !i_riscv_falign_flush;
    assign o_riscv_falign_nextpc  = i_riscv_falign_flush ? i_riscv_falign_target :
                                    adv ? step_pc : i_riscv_falign_pc;

`ifdef RISCV_FALIGN_RVC_EN
    typedef enum logic {ALIGNED, SPLIT} state_t;

    state_t      state_q, state_d;
    logic [15:0] held_half;
    logic [width-1:0] held_pc;
    logic        capture;
    logic [15:0] lo, hi;

    assign lo = i_riscv_falign_rdata[15:0];
    assign hi = i_riscv_falign_rdata[31:16];

    always_comb begin
        emit       = 1'b0;
        emit_instr = 32'h0;
        emit_pc    = i_riscv_falign_pc;
        emit_c     = 1'b0;
        capture    = 1'b0;
        step_pc    = i_riscv_falign_pc + width'(2);
        state_d    = state_q;
        case (state_q)
            ALIGNED: begin
                if (!i_riscv_falign_pc[1]) begin
                    emit = 1'b1;
                    if (lo[1:0] != 2'b11) begin
                        emit_instr = {16'h0, lo};
                        emit_c     = 1'b1;
                    end else begin
                        emit_instr = i_riscv_falign_rdata;
                        step_pc    = i_riscv_falign_pc + width'(4);
                    end
                end else if (hi[1:0] != 2'b11) begin
                    emit       = 1'b1;
                    emit_instr = {16'h0, hi};
                    emit_c     = 1'b1;
                end else begin
                    // upper half starts a 32-bit instruction; its tail is in the next word
                    capture = 1'b1;
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                emit       = 1'b1;
                emit_instr = {lo, held_half};
                emit_pc    = held_pc;
                state_d    = ALIGNED;
            end
            default: state_d = ALIGNED;
        endcase
    end

    always_ff @(posedge i_riscv_falign_clk or negedge i_riscv_falign_rst_n) begin
        if (!i_riscv_falign_rst_n) begin
            state_q   <= ALIGNED;
            held_half <= 16'h0;
            held_pc   <= '0;
        end else if (i_riscv_falign_flush) begin
            state_q <= ALIGNED;
        end else if (adv) begin
            state_q <= state_d;
            if (capture) begin
                held_half <= hi;
                held_pc   <= i_riscv_falign_pc;
            end
        end
    end

    assign o_riscv_falign_misalign = 1'b0;
`else
    logic misalign_q;

    always_comb begin
        emit       = !i_riscv_falign_pc[1];
        emit_instr = i_riscv_falign_rdata;
        emit_pc    = i_riscv_falign_pc;
        emit_c     = 1'b0;
        // a halfword-aligned pc is a trap condition: park on it until redirected
        step_pc    = i_riscv_falign_pc[1] ? i_riscv_falign_pc : i_riscv_falign_pc + width'(4);
    end

    always_ff @(posedge i_riscv_falign_clk or negedge i_riscv_falign_rst_n) begin
        if (!i_riscv_falign_rst_n)
            misalign_q <= 1'b0;
        else if (i_riscv_falign_flush)
            misalign_q <= 1'b0;
        else if (!i_riscv_falign_stall)
            misalign_q <= adv && i_riscv_falign_pc[1];
    end

    assign o_riscv_falign_misalign = misalign_q;
`endif

    always_ff @(posedge i_riscv_falign_clk or negedge i_riscv_falign_rst_n) begin
        if (!i_riscv_falign_rst_n) begin
            o_riscv_falign_instr         <= 32'h0;
            o_riscv_falign_instr_pc      <= '0;
            o_riscv_falign_instr_valid   <= 1'b0;
            o_riscv_falign_is_compressed <= 1'b0;
        end else if (i_riscv_falign_flush) begin
            o_riscv_falign_instr_valid <= 1'b0;
        end else if (!i_riscv_falign_stall) begin
            o_riscv_falign_instr_valid <= adv && emit;
            if (adv && emit) begin
                o_riscv_falign_instr         <= emit_instr;
                o_riscv_falign_instr_pc      <= emit_pc;
                o_riscv_falign_is_compressed <= emit_c;
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_align.sv
// Bench for riscv_fetch_align: directed vectors, a per-cycle reference model and literal pins.
module tb_riscv_fetch_align;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] pc, target;
    logic         rvalid, stall, flush;
    logic [31:0]  rdata;
    logic [W-1:0] nextpc, instr_pc;
    logic         stallpc, instr_valid, is_c, misalign;
    logic [31:0]  instr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_fetch_align #(.width(W)) dut (
        .i_riscv_falign_clk(clk),
        .i_riscv_falign_rst_n(rst_n),
        .i_riscv_falign_pc(pc),
        .i_riscv_falign_rvalid(rvalid),
        .i_riscv_falign_rdata(rdata),
        .i_riscv_falign_stall(stall),
        .i_riscv_falign_flush(flush),
        .i_riscv_falign_target(target),
        .o_riscv_falign_nextpc(nextpc),
        .o_riscv_falign_stallpc(stallpc),
        .o_riscv_falign_instr(instr),
        .o_riscv_falign_instr_pc(instr_pc),
        .o_riscv_falign_instr_valid(instr_valid),
        .o_riscv_falign_is_compressed(is_c),
        .o_riscv_falign_misalign(misalign)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // reference model: a pending upper half is the only memory between words
    logic         m_pend;
    logic [15:0]  m_half;
    logic [W-1:0] m_hpc;
    logic [31:0]  m_instr;
    logic [W-1:0] m_ipc;
    logic         m_valid, m_c, m_mis;

    logic [W-1:0] e_next;
    logic         e_stall, e_emit, e_c, e_start, e_mis;
    logic [31:0]  e_instr;
    logic [W-1:0] e_ipc;
    logic [15:0]  h_at_pc;

    always_comb begin
        e_next  = pc;
        e_stall = 1'b1;
        e_emit  = 1'b0;
        e_c     = 1'b0;
        e_start = 1'b0;
        e_mis   = 1'b0;
        e_instr = 32'h0;
        e_ipc   = pc;
        h_at_pc = pc[1] ? rdata[31:16] : rdata[15:0];
        if (flush) begin
            e_next  = target;
            e_stall = 1'b0;
        end else if (!stall && rvalid) begin
            e_stall = 1'b0;
`ifdef RISCV_FALIGN_RVC_EN
            if (m_pend) begin
                e_emit  = 1'b1;
                e_instr = {rdata[15:0], m_half};
                e_ipc   = m_hpc;
                e_next  = pc + 2;
            end else if (h_at_pc[1:0] != 2'b11) begin
                e_emit  = 1'b1;
                e_c     = 1'b1;
                e_instr = {16'h0, h_at_pc};
                e_next  = pc + 2;
            end else if (pc[1] == 1'b0) begin
                e_emit  = 1'b1;
                e_instr = rdata;
                e_next  = pc + 4;
            end else begin
                e_start = 1'b1;
                e_next  = pc + 2;
            end
`else
            if (pc[1]) begin
                e_mis  = 1'b1;
                e_next = pc;
            end else begin
                e_emit  = 1'b1;
                e_instr = rdata;
                e_next  = pc + 4;
            end
`endif
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend <= 1'b0; m_half <= 16'h0; m_hpc <= '0;
            m_instr <= 32'h0; m_ipc <= '0; m_valid <= 1'b0; m_c <= 1'b0; m_mis <= 1'b0;
        end else if (flush) begin
            m_pend <= 1'b0; m_valid <= 1'b0; m_mis <= 1'b0;
        end else if (!stall) begin
            m_valid <= e_emit;
            m_mis   <= e_mis;
            if (rvalid) begin
                if (e_start) begin
                    m_pend <= 1'b1; m_half <= rdata[31:16]; m_hpc <= pc;
                end else begin
                    m_pend <= 1'b0;
                end
            end
            if (e_emit) begin
                m_instr <= e_instr; m_ipc <= e_ipc; m_c <= e_c;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_nextpc", nextpc, e_next);
            chk("m_stallpc", {63'h0, stallpc}, {63'h0, e_stall});
            chk("m_valid", {63'h0, instr_valid}, {63'h0, m_valid});
            chk("m_misalign", {63'h0, misalign}, {63'h0, m_mis});
            if (m_valid) begin
                chk("m_instr", {32'h0, instr}, {32'h0, m_instr});
                chk("m_instr_pc", instr_pc, m_ipc);
                chk("m_is_c", {63'h0, is_c}, {63'h0, m_c});
            end
        end
    end

    task automatic drive(input logic [W-1:0] p, input logic [31:0] d, input logic v,
                         input logic s, input logic f, input logic [W-1:0] t);
        pc = p; rdata = d; rvalid = v; stall = s; flush = f; target = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_instr"}, {32'h0, instr}, 64'h0);
        chk({tag, "_ipc"}, instr_pc, 64'h0);
        chk({tag, "_valid"}, {63'h0, instr_valid}, 64'h0);
        chk({tag, "_c"}, {63'h0, is_c}, 64'h0);
        chk({tag, "_mis"}, {63'h0, misalign}, 64'h0);
    endtask

    logic [31:0] hold_instr;

    initial begin
        rst_n = 1'b0;
        drive('0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        #12;
        chk_zero("reset");
        tick();
        rst_n = 1'b1;

        // 32-bit instruction on an aligned word
        drive(64'h1000, 32'h00A00093, 1, 0, 0, '0);
        chk("a_nextpc", nextpc, 64'h1004);
        chk("a_stallpc", {63'h0, stallpc}, 64'h0);
        tick();
        chk("a_instr", {32'h0, instr}, 64'h00A00093);
        chk("a_ipc", instr_pc, 64'h1000);
        chk("a_valid", {63'h0, instr_valid}, 64'h1);
        chk("a_c", {63'h0, is_c}, 64'h0);

        drive(64'h1000, 32'h00934505, 1, 0, 0, '0);
`ifdef RISCV_FALIGN_RVC_EN
        chk("b_nextpc", nextpc, 64'h1002);
        tick();
        chk("b_instr", {32'h0, instr}, 64'h00004505);
        chk("b_c", {63'h0, is_c}, 64'h1);
`else
        chk("b_nextpc", nextpc, 64'h1004);
        tick();
        chk("b_instr", {32'h0, instr}, 64'h00934505);
        chk("b_c", {63'h0, is_c}, 64'h0);
`endif

        drive(64'h1002, 32'h00934505, 1, 0, 0, '0);
`ifdef RISCV_FALIGN_RVC_EN
        chk("c_nextpc", nextpc, 64'h1004);
        tick();
        chk("c_valid", {63'h0, instr_valid}, 64'h0);
        drive(64'h1004, 32'h000000A0, 1, 0, 0, '0);
        chk("d_nextpc", nextpc, 64'h1006);
        tick();
        chk("d_instr", {32'h0, instr}, 64'h00A00093);
        chk("d_ipc", instr_pc, 64'h1002);
        chk("d_c", {63'h0, is_c}, 64'h0);
`else
        chk("c_nextpc", nextpc, 64'h1002);
        chk("c_stallpc", {63'h0, stallpc}, 64'h0);
        tick();
        chk("c_valid", {63'h0, instr_valid}, 64'h0);
        chk("c_mis", {63'h0, misalign}, 64'h1);
        drive(64'h1004, 32'h000000A0, 1, 0, 0, '0);
        tick();
        chk("d_mis", {63'h0, misalign}, 64'h0);
        chk("d_instr", {32'h0, instr}, 64'h000000A0);
`endif

        // flush while a half is pending (or while parked on a misaligned pc)
        drive(64'h1002, 32'h00934505, 1, 0, 0, '0);
        tick();
        drive(64'h1004, 32'h00934505, 1, 0, 1, 64'h2000);
        chk("e_nextpc", nextpc, 64'h2000);
        chk("e_stallpc", {63'h0, stallpc}, 64'h0);
        tick();
        chk("e_valid", {63'h0, instr_valid}, 64'h0);
        drive(64'h2000, 32'h00A00093, 1, 0, 0, '0);
        tick();
        chk("f_instr", {32'h0, instr}, 64'h00A00093);
        chk("f_ipc", instr_pc, 64'h2000);

        // decode stall for three cycles
        hold_instr = instr;
        for (int i = 0; i < 3; i++) begin
            drive(64'h2004, 32'h00010001, 1, 1, 0, '0);
            chk("g_nextpc", nextpc, 64'h2004);
            chk("g_stallpc", {63'h0, stallpc}, 64'h1);
            tick();
            chk("g_instr", {32'h0, instr}, {32'h0, hold_instr});
            chk("g_ipc", instr_pc, 64'h2000);
            chk("g_valid", {63'h0, instr_valid}, 64'h1);
        end
        drive(64'h2004, 32'h00A00093, 1, 0, 0, '0);
        tick();
        chk("g_resume_ipc", instr_pc, 64'h2004);

        // fetch bubble of two cycles, across a pending half in RVC builds
        drive(64'h2006, 32'h00934505, 1, 0, 0, '0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(64'h2008, 32'h000000A0, 0, 0, 0, '0);
            chk("h_stallpc", {63'h0, stallpc}, 64'h1);
            chk("h_nextpc", nextpc, 64'h2008);
            tick();
            chk("h_valid", {63'h0, instr_valid}, 64'h0);
        end
        drive(64'h2008, 32'h000000A0, 1, 0, 0, '0);
        tick();
`ifdef RISCV_FALIGN_RVC_EN
        chk("h_instr", {32'h0, instr}, 64'h00A00093);
        chk("h_ipc", instr_pc, 64'h2006);
        drive(64'hFFFF_FFFF_FFFF_FFFE, 32'h00010000, 1, 0, 0, '0);
`else
        drive(64'hFFFF_FFFF_FFFF_FFFC, 32'h00A00093, 1, 0, 0, '0);
`endif
        chk("i_wrap", nextpc, 64'h0);
        tick();

        // asynchronous reset while a half is pending / misalign is raised
        drive(64'h1002, 32'h00934505, 1, 0, 0, '0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("areset");
        tick();
        rst_n = 1'b1;
        drive(64'h3000, 32'h00A00093, 1, 0, 0, '0);
        tick();
        chk("k_ipc", instr_pc, 64'h3000);
        chk("k_valid", {63'h0, instr_valid}, 64'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
